// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared opcode and state encodings for the multiply/divide engine
package md_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_ZERO = 2'd3
    } state_t;

endpackage

// File: rtl/md_addsub.sv
// rtl/md_addsub.sv - combinational add/subtract with carry-out, shared by Booth and divide steps
module md_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_full;

    // Subtraction as x + ~y + 1; carry-out high means no borrow.
    assign w_full = {1'b0, i_x} + {1'b0, (i_sub ? ~i_y : i_y)} + {{W{1'b0}}, i_sub};
    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed MULT/DIV engine owning the HI/LO registers
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int AW = WIDTH + 1;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic [WIDTH-1:0]   r_m;
    logic [AW-1:0]      r_phi;
    logic [WIDTH-1:0]   r_plo;
    logic               r_qm1;
    logic               r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_busy, r_done, r_dz;

    logic [AW-1:0]      w_x, w_y, w_sum, w_acc;
    logic               w_sub, w_cout, w_booth_add;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;

    assign w_abs_a     = src_a[WIDTH-1] ? -src_a : src_a;
    assign w_abs_b     = src_b[WIDTH-1] ? -src_b : src_b;
    assign w_booth_add = r_plo[0] ^ r_qm1;

    // MULT: Booth add/sub of the multiplicand into P_hi.
    // DIV: trial subtraction of |b| from the remainder shifted left by one dividend bit.
    always_comb begin
        w_x   = r_phi;
        w_y   = {r_m[WIDTH-1], r_m};
        w_sub = r_plo[0] & ~r_qm1;
        if (r_op == OP_DIV) begin
            w_x   = {r_phi[WIDTH-1:0], r_plo[WIDTH-1]};
            w_y   = {1'b0, r_m};
            w_sub = 1'b1;
        end
    end

    md_addsub #(.W(AW)) u_addsub (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_sub  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc = w_booth_add ? w_sum : r_phi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (op == OP_DIV && src_b == '0) ? S_ZERO : S_RUN;
            S_RUN:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            S_ZERO: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_m     <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_qm1   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op   <= op;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                    r_phi  <= '0;
                    r_qm1  <= 1'b0;
                    if (op == OP_DIV) begin
                        r_m     <= w_abs_b;
                        r_plo   <= w_abs_a;
                        r_neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                        r_neg_r <= src_a[WIDTH-1];
                    end else begin
                        r_m     <= src_a;
                        r_plo   <= src_b;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == OP_DIV) begin
                        r_phi <= w_cout ? w_sum : w_x;
                        r_plo <= {r_plo[WIDTH-2:0], w_cout};
                    end else begin
                        r_phi <= {w_acc[AW-1], w_acc[AW-1:1]};
                        r_plo <= {w_acc[0], r_plo[WIDTH-1:1]};
                        r_qm1 <= r_plo[0];
                    end
                end
                S_FIX: begin
                    if (r_op == OP_DIV) begin
                        r_lo <= r_neg_q ? -r_plo : r_plo;
                        r_hi <= r_neg_r ? -r_phi[WIDTH-1:0] : r_phi[WIDTH-1:0];
                    end else begin
                        r_lo <= r_plo;
                        r_hi <= r_phi[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_ZERO: begin
                    r_dz   <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start, op;
    logic [31:0] src_a, src_b;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference model: a request occupies the unit for a fixed number of edges, then lands.
    logic        m_busy, m_done, m_dz, m_zero;
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
    int          m_timer;

    always @(posedge clock or posedge reset) begin
        logic [63:0] res;
        if (reset) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_zero = 0;
            m_hi = 0; m_lo = 0; m_rhi = 0; m_rlo = 0; m_timer = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_busy) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_busy = 0;
                    if (m_zero) m_dz = 1;
                    else begin
                        m_done = 1;
                        m_hi = m_rhi;
                        m_lo = m_rlo;
                    end
                end
            end else if (start) begin
                m_busy = 1;
                if (op && src_b == 0) begin
                    m_zero  = 1;
                    m_timer = 1;
                end else begin
                    m_zero  = 0;
                    m_timer = 33;
                    res     = ref_result(op, src_a, src_b);
                    m_rhi   = res[63:32];
                    m_rlo   = res[31:0];
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("div_zero", 64'(div_zero), 64'(m_dz));
            check("hi_out", 64'(hi_out), 64'(m_hi));
            check("lo_out", 64'(lo_out), 64'(m_lo));
        end
    end

    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called half a cycle after edge 'base'; returns the edge index where done/div_zero appeared.
    task automatic wait_end(input int base, output int edge_no);
        edge_no = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (done || div_zero) begin
                edge_no = base + i;
                break;
            end
        end
        if (edge_no < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout waiting for done/div_zero at %0t", $time);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e;
        start = 0; op = 0; src_a = 0; src_b = 0;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        issue(1'b0, 32'd6, -32'sd7);
        check("t1_busy_edge0", 64'(busy), 64'd1);
        wait_end(0, e);
        check("t1_done_edge", 64'(e), 64'd33);
        check("t1_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("t1_lo", 64'(lo_out), 64'hFFFF_FFD6);
        check("t1_busy_low", 64'(busy), 64'd0);

        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_end(0, e);
        check("t2a_hi", 64'(hi_out), 64'h4000_0000);
        check("t2a_lo", 64'(lo_out), 64'h0);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_end(0, e);
        check("t2b_hi", 64'(hi_out), 64'h0);
        check("t2b_lo", 64'(lo_out), 64'h1);

        issue(1'b1, -32'sd7, 32'd2);
        wait_end(0, e);
        check("t3a_lo", 64'(lo_out), 64'hFFFF_FFFD);
        check("t3a_hi", 64'(hi_out), 64'hFFFF_FFFF);
        issue(1'b1, 32'd7, -32'sd2);
        wait_end(0, e);
        check("t3b_lo", 64'(lo_out), 64'hFFFF_FFFD);
        check("t3b_hi", 64'(hi_out), 64'h1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_end(0, e);
        check("t3c_lo", 64'(lo_out), 64'h8000_0000);
        check("t3c_hi", 64'(hi_out), 64'h0);

        issue(1'b1, 32'h2211, 32'h100);
        wait_end(0, e);
        check("t4_pre_hi", 64'(hi_out), 64'h11);
        check("t4_pre_lo", 64'(lo_out), 64'h22);
        issue(1'b1, 32'd5, 32'd0);
        wait_end(0, e);
        check("t4_dz_edge", 64'(e), 64'd1);
        check("t4_dz", 64'(div_zero), 64'd1);
        check("t4_no_done", 64'(done), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_hi", 64'(hi_out), 64'h11);
        check("t4_lo", 64'(lo_out), 64'h22);
        @(negedge clock);
        check("t4_dz_pulse", 64'(div_zero), 64'd0);

        issue(1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clock);
        start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        wait_end(5, e);
        check("t5_done_edge", 64'(e), 64'd33);
        check("t5_lo", 64'(lo_out), 64'd12);
        issue(1'b1, 32'd9, 32'd3);
        wait_end(0, e);
        check("t5b_lo", 64'(lo_out), 64'd3);
        check("t5b_hi", 64'(hi_out), 64'd0);

        issue(1'b0, 32'h1234, 32'h5678);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_hi", 64'(hi_out), 64'd0);
        check("t6_lo", 64'(lo_out), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        issue(1'b0, 32'd2, 32'd3);
        wait_end(0, e);
        check("t6_done_edge", 64'(e), 64'd33);
        check("t6_lo", 64'(lo_out), 64'd6);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            start = ($urandom_range(0, 3) == 0);
            op    = 1'($urandom_range(0, 1));
            src_a = pick();
            src_b = pick();
        end
        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
